// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle CPU control unit: IF/ID/EXE/MEM/WB sequencer driving every datapath strobe.
// Outputs are combinational from (state, opcode, zero); 2-5 cycles per instruction, halt parks in ID until rst.
module multicycle_ctrl_fsm #(
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               zero,
  output logic               PCWre,
  output logic               IRWre,
  output logic               RegWre,
  output logic               WrRegData,
  output logic [1:0]         RegOut,
  output logic               ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               ExtSel,
  output logic               ALUM2Reg,
  output logic               DataMemRW,
  output logic [1:0]         PCSrc,
  output logic [2:0]         state
);

  localparam logic [5:0] OpAdd  = 6'b000000;
  localparam logic [5:0] OpSub  = 6'b000001;
  localparam logic [5:0] OpAddi = 6'b000010;
  localparam logic [5:0] OpOr   = 6'b010000;
  localparam logic [5:0] OpAnd  = 6'b010001;
  localparam logic [5:0] OpOri  = 6'b010010;
  localparam logic [5:0] OpSlt  = 6'b100110;
  localparam logic [5:0] OpSw   = 6'b110000;
  localparam logic [5:0] OpLw   = 6'b110001;
  localparam logic [5:0] OpBeq  = 6'b110100;
  localparam logic [5:0] OpJ    = 6'b111000;
  localparam logic [5:0] OpJr   = 6'b111001;
  localparam logic [5:0] OpJal  = 6'b111010;
  localparam logic [5:0] OpHalt = 6'b111111;

  localparam logic [ALUOP_W-1:0] AluAdd = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] AluSub = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] AluOr  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] AluAnd = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] AluSlt = ALUOP_W'(4);

  localparam logic [1:0] PcNext   = 2'b00;
  localparam logic [1:0] PcBranch = 2'b01;
  localparam logic [1:0] PcReg    = 2'b10;
  localparam logic [1:0] PcJump   = 2'b11;

  localparam logic [1:0] DstRa = 2'b00;
  localparam logic [1:0] DstRt = 2'b01;
  localparam logic [1:0] DstRd = 2'b10;

  typedef enum logic [2:0] {
    sIf    = 3'd0,
    sId    = 3'd1,
    sExeAl = 3'd2,
    sExeBr = 3'd3,
    sExeLs = 3'd4,
    sMem   = 3'd5,
    sWbAl  = 3'd6,
    sWbLd  = 3'd7
  } ctrlState_t;

  ctrlState_t curState, nextState;
  logic       haltQ;
  logic       haltSet;

  logic isRType, isAluImm, isAlu;
  logic pcWreRaw, irWreRaw, regWreRaw, memWrRaw;

  function automatic logic [ALUOP_W-1:0] aluOpFor(input logic [5:0] op);
    logic [ALUOP_W-1:0] f;
    f = AluAdd;
    case (op)
      OpSub:        f = AluSub;
      OpOr, OpOri:  f = AluOr;
      OpAnd:        f = AluAnd;
      OpSlt:        f = AluSlt;
      default:      f = AluAdd;
    endcase
    return f;
  endfunction

  always_comb begin
    isRType  = (opcode == OpAdd) || (opcode == OpSub) || (opcode == OpOr) ||
               (opcode == OpAnd) || (opcode == OpSlt);
    isAluImm = (opcode == OpAddi) || (opcode == OpOri);
    isAlu    = isRType || isAluImm;
  end

  // Once halt is decoded it sticks even if the opcode input later wanders.
  assign haltSet = (curState == sId) && (opcode == OpHalt);

  always_ff @(posedge clk) begin
    if (rst) begin
      curState <= sIf;
      haltQ    <= 1'b0;
    end else begin
      curState <= nextState;
      haltQ    <= haltQ | haltSet;
    end
  end

  always_comb begin
    nextState = curState;
    pcWreRaw  = 1'b0;
    irWreRaw  = 1'b0;
    regWreRaw = 1'b0;
    memWrRaw  = 1'b0;
    WrRegData = 1'b0;
    RegOut    = DstRa;
    ALUSrcB   = 1'b0;
    ALUOp     = AluAdd;
    ExtSel    = 1'b0;
    ALUM2Reg  = 1'b0;
    PCSrc     = PcNext;

    case (curState)
      sIf: begin
        irWreRaw  = 1'b1;
        nextState = sId;
      end

      sId: begin
        if (haltQ || opcode == OpHalt) begin
          nextState = sId;
        end else if (isAlu) begin
          nextState = sExeAl;
        end else begin
          case (opcode)
            OpBeq:      nextState = sExeBr;
            OpLw, OpSw: nextState = sExeLs;
            OpJ: begin
              pcWreRaw  = 1'b1;
              PCSrc     = PcJump;
              nextState = sIf;
            end
            OpJr: begin
              pcWreRaw  = 1'b1;
              PCSrc     = PcReg;
              nextState = sIf;
            end
            OpJal: begin
              pcWreRaw  = 1'b1;
              PCSrc     = PcJump;
              regWreRaw = 1'b1;
              RegOut    = DstRa;
              WrRegData = 1'b0;
              nextState = sIf;
            end
            // Undefined opcodes retire as a nop.
            default: begin
              pcWreRaw  = 1'b1;
              PCSrc     = PcNext;
              nextState = sIf;
            end
          endcase
        end
      end

      sExeAl: begin
        ALUSrcB   = isAluImm;
        ExtSel    = (opcode == OpAddi);
        ALUOp     = aluOpFor(opcode);
        nextState = sWbAl;
      end

      sWbAl: begin
        ALUSrcB   = isAluImm;
        ExtSel    = (opcode == OpAddi);
        ALUOp     = aluOpFor(opcode);
        regWreRaw = 1'b1;
        WrRegData = 1'b1;
        RegOut    = isAluImm ? DstRt : DstRd;
        pcWreRaw  = 1'b1;
        nextState = sIf;
      end

      sExeBr: begin
        ALUOp     = AluSub;
        ExtSel    = 1'b1;
        pcWreRaw  = 1'b1;
        PCSrc     = zero ? PcBranch : PcNext;
        nextState = sIf;
      end

      sExeLs: begin
        ALUSrcB   = 1'b1;
        ExtSel    = 1'b1;
        nextState = sMem;
      end

      sMem: begin
        if (opcode == OpLw) begin
          nextState = sWbLd;
        end else begin
          // Anything other than lw retires here; only sw actually writes memory.
          memWrRaw  = (opcode == OpSw);
          pcWreRaw  = 1'b1;
          nextState = sIf;
        end
      end

      sWbLd: begin
        regWreRaw = 1'b1;
        WrRegData = 1'b1;
        ALUM2Reg  = 1'b1;
        RegOut    = DstRt;
        pcWreRaw  = 1'b1;
        nextState = sIf;
      end

      default: nextState = sIf;
    endcase
  end

  // Architectural side effects are suppressed for as long as reset is held.
  assign PCWre     = pcWreRaw  & ~rst;
  assign IRWre     = irWreRaw  & ~rst;
  assign RegWre    = regWreRaw & ~rst;
  assign DataMemRW = memWrRaw  & ~rst;
  assign state     = curState;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: per-instruction expected cycle tables compared against every output each cycle.
module tb_multicycle_ctrl_fsm;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       PCWre, IRWre, RegWre, WrRegData, ALUSrcB, ExtSel, ALUM2Reg, DataMemRW;
  logic [1:0] RegOut, PCSrc;
  logic [2:0] ALUOp;
  logic [2:0] state;

  int nTests = 0;
  int nFail  = 0;

  logic [17:0] expQ[$];
  logic [17:0] obs;
  logic [5:0]  opList [0:12];

  multicycle_ctrl_fsm #(.ALUOP_W(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .WrRegData(WrRegData),
    .RegOut(RegOut), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel),
    .ALUM2Reg(ALUM2Reg), .DataMemRW(DataMemRW), .PCSrc(PCSrc), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {state, PCWre, IRWre, RegWre, WrRegData, RegOut, ALUSrcB,
                ALUOp, ExtSel, ALUM2Reg, DataMemRW, PCSrc};

  // One expected output vector: state, PCWre, IRWre, RegWre, WrRegData, RegOut,
  // ALUSrcB, ALUOp, ExtSel, ALUM2Reg, DataMemRW, PCSrc.
  function automatic logic [17:0] mk(input logic [2:0] st, input logic pcw, input logic irw,
                                     input logic rw, input logic wrd, input logic [1:0] ro,
                                     input logic asb, input logic [2:0] aop, input logic ext,
                                     input logic am, input logic dmw, input logic [1:0] pcs);
    return {st, pcw, irw, rw, wrd, ro, asb, aop, ext, am, dmw, pcs};
  endfunction

  function automatic bit isDefined(input logic [5:0] op);
    bit d;
    d = (op == OP_HALT);
    for (int k = 0; k < 13; k++) if (opList[k] == op) d = 1'b1;
    return d;
  endfunction

  // Reference: the full cycle-by-cycle output table of one instruction, starting at fetch.
  task automatic buildExp(input logic [5:0] op, input logic z);
    logic [2:0]  aop;
    logic [17:0] idQuiet;
    expQ.delete();
    idQuiet = mk(3'd1, 0, 0, 0, 0, 2'b00, 0, 3'd0, 0, 0, 0, 2'b00);
    expQ.push_back(mk(3'd0, 0, 1, 0, 0, 2'b00, 0, 3'd0, 0, 0, 0, 2'b00));
    aop = 3'd0;
    case (op)
      OP_SUB: aop = 3'd1;
      OP_OR:  aop = 3'd2;
      OP_AND: aop = 3'd3;
      OP_SLT: aop = 3'd4;
      default: aop = 3'd0;
    endcase
    case (op)
      OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLT: begin
        expQ.push_back(idQuiet);
        expQ.push_back(mk(3'd2, 0, 0, 0, 0, 2'b00, 0, aop, 0, 0, 0, 2'b00));
        expQ.push_back(mk(3'd6, 1, 0, 1, 1, 2'b10, 0, aop, 0, 0, 0, 2'b00));
      end
      OP_ADDI: begin
        expQ.push_back(idQuiet);
        expQ.push_back(mk(3'd2, 0, 0, 0, 0, 2'b00, 1, 3'd0, 1, 0, 0, 2'b00));
        expQ.push_back(mk(3'd6, 1, 0, 1, 1, 2'b01, 1, 3'd0, 1, 0, 0, 2'b00));
      end
      OP_ORI: begin
        expQ.push_back(idQuiet);
        expQ.push_back(mk(3'd2, 0, 0, 0, 0, 2'b00, 1, 3'd2, 0, 0, 0, 2'b00));
        expQ.push_back(mk(3'd6, 1, 0, 1, 1, 2'b01, 1, 3'd2, 0, 0, 0, 2'b00));
      end
      OP_BEQ: begin
        expQ.push_back(idQuiet);
        expQ.push_back(mk(3'd3, 1, 0, 0, 0, 2'b00, 0, 3'd1, 1, 0, 0, z ? 2'b01 : 2'b00));
      end
      OP_LW: begin
        expQ.push_back(idQuiet);
        expQ.push_back(mk(3'd4, 0, 0, 0, 0, 2'b00, 1, 3'd0, 1, 0, 0, 2'b00));
        expQ.push_back(mk(3'd5, 0, 0, 0, 0, 2'b00, 0, 3'd0, 0, 0, 0, 2'b00));
        expQ.push_back(mk(3'd7, 1, 0, 1, 1, 2'b01, 0, 3'd0, 0, 1, 0, 2'b00));
      end
      OP_SW: begin
        expQ.push_back(idQuiet);
        expQ.push_back(mk(3'd4, 0, 0, 0, 0, 2'b00, 1, 3'd0, 1, 0, 0, 2'b00));
        expQ.push_back(mk(3'd5, 1, 0, 0, 0, 2'b00, 0, 3'd0, 0, 0, 1, 2'b00));
      end
      OP_J:    expQ.push_back(mk(3'd1, 1, 0, 0, 0, 2'b00, 0, 3'd0, 0, 0, 0, 2'b11));
      OP_JR:   expQ.push_back(mk(3'd1, 1, 0, 0, 0, 2'b00, 0, 3'd0, 0, 0, 0, 2'b10));
      OP_JAL:  expQ.push_back(mk(3'd1, 1, 0, 1, 0, 2'b00, 0, 3'd0, 0, 0, 0, 2'b11));
      OP_HALT: expQ.push_back(idQuiet);
      default: expQ.push_back(mk(3'd1, 1, 0, 0, 0, 2'b00, 0, 3'd0, 0, 0, 0, 2'b00));
    endcase
  endtask

  task automatic test_reset();
    rst = 1'b1; opcode = 6'b101010; zero = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    nTests++;
    if ({state, PCWre, IRWre, RegWre, DataMemRW} !== {3'd0, 4'b0000}) begin
      nFail++;
      $display("FAIL reset_held: got state=%0d PCWre=%b IRWre=%b RegWre=%b DataMemRW=%b, expected state=0 and all 0",
               state, PCWre, IRWre, RegWre, DataMemRW);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    // Fetch right after release, then an undefined opcode retires as nop.
    buildExp(opcode, zero);
    foreach (expQ[i]) begin
      @(negedge clk);
      nTests++;
      if (obs !== expQ[i]) begin
        nFail++;
        $display("FAIL reset_then_nop cycle %0d: got %h expected %h", i, obs, expQ[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu();
    logic [5:0] ops [0:6];
    ops = '{OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLT, OP_ADDI, OP_ORI};
    for (int n = 0; n < 7; n++) begin
      opcode = ops[n]; zero = 1'($urandom_range(0, 1));
      buildExp(opcode, zero);
      foreach (expQ[i]) begin
        @(negedge clk);
        nTests++;
        if (obs !== expQ[i]) begin
          nFail++;
          $display("FAIL alu op=%b cycle %0d: got %h expected %h", opcode, i, obs, expQ[i]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_load_store_branch_jump();
    logic [5:0] ops [0:6];
    logic       zs  [0:6];
    ops = '{OP_LW, OP_SW, OP_BEQ, OP_BEQ, OP_J, OP_JR, OP_JAL};
    zs  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int n = 0; n < 7; n++) begin
      opcode = ops[n]; zero = zs[n];
      buildExp(opcode, zero);
      foreach (expQ[i]) begin
        @(negedge clk);
        nTests++;
        if (obs !== expQ[i]) begin
          nFail++;
          $display("FAIL ctl op=%b zero=%b cycle %0d: got %h expected %h", opcode, zero, i, obs, expQ[i]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_halt();
    opcode = OP_HALT; zero = 1'b0;
    buildExp(OP_HALT, 1'b0);
    for (int k = 0; k < 19; k++) expQ.push_back(expQ[1]);
    foreach (expQ[i]) begin
      @(negedge clk);
      nTests++;
      if (obs !== expQ[i]) begin
        nFail++;
        $display("FAIL halt cycle %0d: got %h expected %h", i, obs, expQ[i]);
      end
      @(posedge clk); #1;
      if (i == 1) opcode = OP_ADD;
    end
    rst = 1'b1;
    @(negedge clk);
    nTests++;
    if ({state, PCWre, IRWre, RegWre, DataMemRW} !== {3'd1, 4'b0000}) begin
      nFail++;
      $display("FAIL halt_rst: got state=%0d enables=%b%b%b%b expected state=1 enables=0000",
               state, PCWre, IRWre, RegWre, DataMemRW);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    opcode = OP_ADD;
    buildExp(OP_ADD, 1'b0);
    foreach (expQ[i]) begin
      @(negedge clk);
      nTests++;
      if (obs !== expQ[i]) begin
        nFail++;
        $display("FAIL after_halt cycle %0d: got %h expected %h", i, obs, expQ[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_in_mem();
    logic [5:0] ops [0:1];
    ops = '{OP_LW, OP_SW};
    for (int n = 0; n < 2; n++) begin
      opcode = ops[n]; zero = 1'b0;
      buildExp(opcode, zero);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        nTests++;
        if (obs !== expQ[i]) begin
          nFail++;
          $display("FAIL rst_mem_pre op=%b cycle %0d: got %h expected %h", opcode, i, obs, expQ[i]);
        end
        @(posedge clk); #1;
      end
      rst = 1'b1;
      @(negedge clk);
      nTests++;
      if (obs !== mk(3'd5, 0, 0, 0, 0, 2'b00, 0, 3'd0, 0, 0, 0, 2'b00)) begin
        nFail++;
        $display("FAIL rst_mem_hold op=%b: got %h expected %h", opcode, obs,
                 mk(3'd5, 0, 0, 0, 0, 2'b00, 0, 3'd0, 0, 0, 0, 2'b00));
      end
      @(posedge clk); #1;
      rst = 1'b0;
    end
    opcode = OP_ADDI;
    buildExp(OP_ADDI, 1'b0);
    foreach (expQ[i]) begin
      @(negedge clk);
      nTests++;
      if (obs !== expQ[i]) begin
        nFail++;
        $display("FAIL rst_mem_restart cycle %0d: got %h expected %h", i, obs, expQ[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back_random();
    logic [5:0] op;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        op = 6'($urandom_range(0, 63));
        while (isDefined(op)) op = 6'($urandom_range(0, 63));
      end else begin
        op = opList[$urandom_range(0, 12)];
      end
      opcode = op; zero = 1'($urandom_range(0, 1));
      buildExp(opcode, zero);
      foreach (expQ[i]) begin
        @(negedge clk);
        nTests++;
        if (obs !== expQ[i]) begin
          nFail++;
          $display("FAIL random #%0d op=%b zero=%b cycle %0d: got %h expected %h",
                   n, opcode, zero, i, obs, expQ[i]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    opList = '{OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLT,
               OP_SW, OP_LW, OP_BEQ, OP_J, OP_JR, OP_JAL};
    rst = 1'b1; opcode = 6'b0; zero = 1'b0;
    test_reset();
    test_alu();
    test_load_store_branch_jump();
    test_halt();
    test_reset_in_mem();
    test_back_to_back_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
